pdp8_mem_responder: RTL

// - Memory-side responder for the CPU memory bus: address, write_data, write_enable, mem_load in; read_data, mem_ready out.
// - Holds a DEPTH x 12-bit word store and answers each CPU read or write after WAIT_STATES wait cycles.
// - Sits between the CPU core and the testbench/top level; a backdoor port preloads programs before or during a run.

---
 rtl/pdp8_mem_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pdp8_mem_responder.sv
// rtl/pdp8_mem_responder.sv - PDP-8 memory-side bus responder with fixed wait states
// and a backdoor preload port.
module pdp8_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic              mem_load,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  output logic              bus_err,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;

  logic [DATA_W-1:0] store [DEPTH];

  logic              req, sample;
  logic [IDX_W-1:0]  eff_idx, init_idx;
  logic [DATA_W-1:0] eff_data;
  logic              eff_write, ack_entry, commit;

  logic [DATA_W-1:0] read_data_nxt;
  logic              mem_ready_nxt, busy_nxt, bus_err_nxt;

  assign req      = write_enable | mem_load;
  assign sample   = (state == S_IDLE) && req;
  assign init_idx = init_addr[IDX_W-1:0];

  // With zero wait states the ACK edge is the sample edge, so use the live inputs.
  assign eff_idx   = sample ? address[IDX_W-1:0] : lat_idx;
  assign eff_data  = sample ? write_data : lat_data;
  assign eff_write = sample ? write_enable : lat_write;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      read_data <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      read_data <= read_data_nxt;
      mem_ready <= mem_ready_nxt;
      busy      <= busy_nxt;
      bus_err   <= bus_err_nxt;
      if (sample) begin
        lat_idx   <= address[IDX_W-1:0];
        lat_data  <= write_data;
        lat_write <= write_enable;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_ACK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ACK never follows ACK, so a next state of ACK always marks the entry edge.
  assign ack_entry = (state_nxt == S_ACK);
  assign commit    = ack_entry && eff_write && nrst;

  always_comb begin
    read_data_nxt = read_data;
    if (ack_entry) read_data_nxt = eff_write ? eff_data : store[eff_idx];
    mem_ready_nxt = ack_entry;
    busy_nxt      = (state_nxt != S_IDLE);
    bus_err_nxt   = sample && write_enable && mem_load;
  end

  // The CPU commit is written last so it wins over a same-edge backdoor write.
  always_ff @(posedge clk) begin
    if (init_we) store[init_idx] <= init_data;
    if (commit)  store[eff_idx]  <= eff_data;
  end

endmodule
